// File: rtl/i2c_target.sv
// i2c_target: single-address I2C target (responder), standard/fast mode, no
// clock stretching. SCL/SDA are sampled through a synchronizer. SDA is only
// ever pulled low through O_SDA_T; the bus wrapper owns the open-drain pad.
//
// Ports:
//   I_CLK       system clock, rising edge
//   I_NRESET    asynchronous active-low reset
//   I_SCL/I_SDA bus lines as read back from the pads
//   O_SDA_T     SDA tri-state control (1 = release, 0 = pull low)
//   I_TX_DATA   next read byte, sampled when a read byte is loaded
//   O_TX_REQ    one-cycle pulse after I_TX_DATA was loaded
//   O_RX_DATA   last byte written by the controller (held)
//   O_RX_VALID  one-cycle pulse when O_RX_DATA updates
//   O_BUSY      high from address ACK until STOP / repeated START / read NACK
module i2c_target #(
  parameter logic [6:0] P_ADDRESS     = 7'h42,
  parameter int         P_SYNC_STAGES = 2
) (
  input  logic       I_CLK,
  input  logic       I_NRESET,
  input  logic       I_SCL,
  input  logic       I_SDA,
  output logic       O_SDA_T,
  input  logic [7:0] I_TX_DATA,
  output logic       O_TX_REQ,
  output logic [7:0] O_RX_DATA,
  output logic       O_RX_VALID,
  output logic       O_BUSY
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_IGNORE
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning. Bus events are registered once more after the edge
  // compare so that every FSM action lands exactly S+2 cycles after the pin.
  // ---------------------------------------------------------------------------
  logic [P_SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_h, sda_h;
  logic ev_rise, ev_fall, ev_start, ev_stop, sda_lvl;

  assign scl_s = scl_sync[P_SYNC_STAGES-1];
  assign sda_s = sda_sync[P_SYNC_STAGES-1];

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_h    <= 1'b1;
      sda_h    <= 1'b1;
      ev_rise  <= 1'b0;
      ev_fall  <= 1'b0;
      ev_start <= 1'b0;
      ev_stop  <= 1'b0;
      sda_lvl  <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[P_SYNC_STAGES-2:0], I_SCL};
      sda_sync <= {sda_sync[P_SYNC_STAGES-2:0], I_SDA};
      scl_h    <= scl_s;
      sda_h    <= sda_s;
      ev_rise  <= scl_s & ~scl_h;
      ev_fall  <= ~scl_s & scl_h;
      ev_start <= scl_s & scl_h & sda_h & ~sda_s;
      ev_stop  <= scl_s & scl_h & ~sda_h & sda_s;
      sda_lvl  <= sda_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol FSM
  // ---------------------------------------------------------------------------
  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;        // bit index within the byte
  logic       done, done_n;      // 8 bits seen, ninth (ACK) clock pending
  logic       rw, rw_n;
  logic [7:0] shreg, shreg_n;
  logic       sda_t, sda_t_n;
  logic       busy, busy_n;
  logic [7:0] rx_data, rx_data_n;
  logic       rx_pend, rx_pend_n;
  logic       rx_valid, rx_valid_n;
  logic       tx_req, tx_req_n;

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state    <= S_IDLE;
      cnt      <= 3'd0;
      done     <= 1'b0;
      rw       <= 1'b0;
      shreg    <= 8'h00;
      sda_t    <= 1'b1;
      busy     <= 1'b0;
      rx_data  <= 8'h00;
      rx_pend  <= 1'b0;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      done     <= done_n;
      rw       <= rw_n;
      shreg    <= shreg_n;
      sda_t    <= sda_t_n;
      busy     <= busy_n;
      rx_data  <= rx_data_n;
      rx_pend  <= rx_pend_n;
      rx_valid <= rx_valid_n;
      tx_req   <= tx_req_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    done_n     = done;
    rw_n       = rw;
    shreg_n    = shreg;
    sda_t_n    = sda_t;
    busy_n     = busy;
    rx_data_n  = rx_data;
    rx_pend_n  = 1'b0;
    rx_valid_n = rx_pend;
    tx_req_n   = 1'b0;

    // STOP / START win over any data event in the same cycle.
    if (ev_stop || ev_start) begin
      state_n = ev_stop ? S_IDLE : S_ADDR;
      cnt_n   = 3'd0;
      done_n  = 1'b0;
      sda_t_n = 1'b1;
      busy_n  = 1'b0;
    end else begin
      unique case (state)
        S_ADDR: begin
          if (ev_rise && !done) begin
            shreg_n = {shreg[6:0], sda_lvl};
            cnt_n   = cnt + 3'd1;
            if (cnt == 3'd7) done_n = 1'b1;
          end else if (ev_fall && done) begin
            done_n = 1'b0;
            rw_n   = shreg[0];
            if (shreg[7:1] == P_ADDRESS) begin
              state_n = S_ADDR_ACK;
              sda_t_n = 1'b0;
              busy_n  = 1'b1;
            end else begin
              state_n = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK: begin
          if (ev_fall) begin
            if (rw) begin
              shreg_n  = I_TX_DATA;
              sda_t_n  = I_TX_DATA[7];
              tx_req_n = 1'b1;
              cnt_n    = 3'd0;
              state_n  = S_READ;
            end else begin
              sda_t_n = 1'b1;
              state_n = S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (ev_rise && !done) begin
            shreg_n = {shreg[6:0], sda_lvl};
            cnt_n   = cnt + 3'd1;
            if (cnt == 3'd7) begin
              done_n    = 1'b1;
              rx_data_n = {shreg[6:0], sda_lvl};
              rx_pend_n = 1'b1;
            end
          end else if (ev_fall && done) begin
            done_n  = 1'b0;
            sda_t_n = 1'b0;
            state_n = S_WRITE_ACK;
          end
        end
        S_WRITE_ACK: begin
          if (ev_fall) begin
            sda_t_n = 1'b1;
            state_n = S_WRITE;
          end
        end
        S_READ: begin
          // Bit 7 went out at load; each fall shifts the next bit out, and
          // the fall after bit 0 hands SDA back for the controller's ACK.
          if (ev_fall) begin
            if (cnt == 3'd7) begin
              sda_t_n = 1'b1;
              state_n = S_READ_ACK;
            end else begin
              cnt_n   = cnt + 3'd1;
              sda_t_n = shreg[6];
              shreg_n = {shreg[6:0], 1'b0};
            end
          end
        end
        S_READ_ACK: begin
          if (ev_rise && !done) begin
            if (sda_lvl) begin
              busy_n  = 1'b0;
              state_n = S_IGNORE;
            end else begin
              done_n = 1'b1;
            end
          end else if (ev_fall && done) begin
            done_n   = 1'b0;
            shreg_n  = I_TX_DATA;
            sda_t_n  = I_TX_DATA[7];
            tx_req_n = 1'b1;
            cnt_n    = 3'd0;
            state_n  = S_READ;
          end
        end
        default: ;  // S_IDLE, S_IGNORE: only bus conditions matter
      endcase
    end
  end

  // A START/STOP releases SDA in the very cycle it is detected, ahead of the
  // registered control catching up on the next edge.
  assign O_SDA_T    = sda_t | ev_start | ev_stop;
  assign O_TX_REQ   = tx_req;
  assign O_RX_DATA  = rx_data;
  assign O_RX_VALID = rx_valid;
  assign O_BUSY     = busy;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed + randomized controller-side stimulus for i2c_target.
// A bit-level I2C controller drives SCL/SDA (SDA wired-AND with the target);
// expectations come from transaction-level rules (address match -> ACK,
// written bytes appear in order, read bytes equal the host's byte stream).
module tb_i2c_target;
  localparam int S = 2;
  localparam int T = 8;  // quarter bit period in clk cycles

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       scl = 1'b1;
  logic       ctrl_sda = 1'b1;
  logic       ignore_target = 1'b0;
  logic [7:0] tx_data;
  logic       sda_t, tx_req, rx_valid, busy;
  logic [7:0] rx_data;
  logic       sda_bus;

  always #5 clk = ~clk;
  assign sda_bus = ctrl_sda & (sda_t | ignore_target);

  i2c_target #(.P_ADDRESS(7'h42), .P_SYNC_STAGES(S)) dut (
    .I_CLK(clk), .I_NRESET(nreset), .I_SCL(scl), .I_SDA(sda_bus),
    .O_SDA_T(sda_t), .I_TX_DATA(tx_data), .O_TX_REQ(tx_req),
    .O_RX_DATA(rx_data), .O_RX_VALID(rx_valid), .O_BUSY(busy)
  );

  int n_checks = 0, n_fails = 0;
  int cyc = 0, fall_cyc = 0, tx_cnt = 0;
  logic [7:0] tx_mem [0:255];
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];
  bit sda_low_seen = 0, busy_seen = 0;
  logic sda_t_prev = 1'b1;

  assign tx_data = tx_mem[tx_cnt[7:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Host side + bus observers
  always @(negedge clk) begin
    if (rx_valid) rx_q.push_back(rx_data);
    if (tx_req) tx_cnt++;
    if (!sda_t) sda_low_seen = 1;
    if (busy) busy_seen = 1;
    if (nreset && sda_t_prev && !sda_t)
      check("sda_t_pull_latency", cyc - fall_cyc, S + 2);
    sda_t_prev = sda_t;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_low();
    scl = 1'b0;
    fall_cyc = cyc;
  endtask

  // Works from idle bus or from SCL low (repeated START).
  task automatic do_start();
    ctrl_sda = 1'b1; tick(T);
    scl = 1'b1;      tick(T);
    ctrl_sda = 1'b0; tick(T);
    scl_low();       tick(T);
  endtask

  task automatic do_stop();
    ctrl_sda = 1'b0; tick(T);
    scl = 1'b1;      tick(T);
    ctrl_sda = 1'b1; tick(T);
  endtask

  task automatic xfer_bit(input logic b, output logic r);
    ctrl_sda = b; tick(T);
    scl = 1'b1;   tick(T);
    r = sda_bus;  tick(T);
    scl_low();    tick(T);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) xfer_bit(d[i], r);
    xfer_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(1'b1, r);
      d[i] = r;
    end
    xfer_bit(nack, r);
  endtask

  logic       ack, r;
  logic [7:0] d;
  logic [6:0] addr;
  int         n, base;
  bit         match;

  initial begin
    for (int i = 0; i < 256; i++) tx_mem[i] = 8'($urandom);

    // ---- reset values
    tick(3);
    check("rst_sda_t", sda_t, 1);
    check("rst_tx_req", tx_req, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rx_data", rx_data, 8'h00);
    nreset = 1'b1;
    tick(5);

    // ---- directed write
    rx_q.delete();
    do_start();
    send_byte(8'h84, ack);
    check("w_addr_ack", ack, 0);
    check("w_busy", busy, 1);
    send_byte(8'hA5, ack);
    check("w_data_ack", ack, 0);
    check("w_busy_pre_stop", busy, 1);
    do_stop();
    tick(T);
    check("w_rx_cnt", rx_q.size(), 1);
    check("w_rx_data", rx_data, 8'hA5);
    check("w_busy_stop", busy, 0);
    check("w_sda_released", sda_t, 1);

    // ---- randomized writes, mixed addresses
    for (int it = 0; it < 6; it++) begin
      addr  = (it % 2 == 0) ? 7'h42 : 7'($urandom_range(0, 127));
      if (it == 5) addr = 7'h00;  // general call
      match = (addr == 7'h42);
      n     = $urandom_range(1, 3);
      rx_q.delete();
      exp_q.delete();
      do_start();
      send_byte({addr, 1'b0}, ack);
      check("rw_addr_ack", ack, match ? 0 : 1);
      for (int j = 0; j < n; j++) begin
        d = 8'($urandom);
        send_byte(d, ack);
        check("rw_data_ack", ack, match ? 0 : 1);
        if (match) exp_q.push_back(d);
      end
      do_stop();
      tick(T);
      check("rw_rx_cnt", rx_q.size(), exp_q.size());
      for (int j = 0; j < exp_q.size() && j < rx_q.size(); j++)
        check("rw_rx_byte", rx_q[j], exp_q[j]);
    end

    // ---- directed read 0x3C (ACK) then 0xF0 (NACK)
    base = tx_cnt;
    tx_mem[8'(base)]     = 8'h3C;
    tx_mem[8'(base + 1)] = 8'hF0;
    do_start();
    send_byte(8'h85, ack);
    check("r_addr_ack", ack, 0);
    read_byte(1'b0, d);
    check("r_byte0", d, 8'h3C);
    read_byte(1'b1, d);
    check("r_byte1", d, 8'hF0);
    tick(2);
    check("r_tx_req_cnt", tx_cnt - base, 2);
    check("r_busy_after_nack", busy, 0);
    check("r_sda_released", sda_t, 1);
    do_stop();

    // ---- randomized reads
    for (int it = 0; it < 4; it++) begin
      n    = $urandom_range(1, 3);
      base = tx_cnt;
      for (int k = 0; k < n; k++) tx_mem[8'(base + k)] = 8'($urandom);
      do_start();
      send_byte({7'h42, 1'b1}, ack);
      check("rr_addr_ack", ack, 0);
      for (int k = 0; k < n; k++) begin
        read_byte(k == n - 1, d);
        check("rr_byte", d, tx_mem[8'(base + k)]);
      end
      tick(2);
      check("rr_tx_req_cnt", tx_cnt - base, n);
      check("rr_busy_after_nack", busy, 0);
      do_stop();
    end

    // ---- wrong address
    rx_q.delete();
    tick(1);
    sda_low_seen = 0;
    busy_seen = 0;
    do_start();
    send_byte(8'h86, ack);
    check("wa_addr_nack", ack, 1);
    send_byte(8'h11, ack);
    check("wa_data_nack", ack, 1);
    do_stop();
    tick(T);
    check("wa_sda_never_low", sda_low_seen, 0);
    check("wa_busy_never", busy_seen, 0);
    check("wa_rx_cnt", rx_q.size(), 0);

    // ---- repeated START drops a partial write byte
    rx_q.delete();
    base = tx_cnt;
    do_start();
    send_byte(8'h84, ack);
    check("rs_w_ack", ack, 0);
    for (int k = 0; k < 4; k++) xfer_bit(1'($urandom), r);
    do_start();
    send_byte(8'h85, ack);
    check("rs_r_ack", ack, 0);
    read_byte(1'b1, d);
    check("rs_r_byte", d, tx_mem[8'(base)]);
    do_stop();
    tick(T);
    check("rs_rx_cnt", rx_q.size(), 0);

    // ---- STOP mid-byte
    rx_q.delete();
    do_start();
    send_byte(8'h84, ack);
    check("sm_ack", ack, 0);
    for (int k = 0; k < 3; k++) xfer_bit(1'($urandom), r);
    do_stop();
    tick(T);
    check("sm_rx_cnt", rx_q.size(), 0);
    check("sm_busy", busy, 0);
    check("sm_sda_t", sda_t, 1);

    // ---- STOP while the target holds the address ACK low
    rx_q.delete();
    do_start();
    for (int i = 7; i >= 0; i--) xfer_bit(d[i] & 1'b0 | (8'h84 >> i) & 1'b1, r);
    ignore_target = 1'b1;
    ctrl_sda = 1'b0; tick(T);
    scl = 1'b1;      tick(T);
    check("sa_ack_held", sda_t, 0);
    ctrl_sda = 1'b1;
    tick(S + 1);
    check("sa_release_now", sda_t, 1);
    tick(2);
    check("sa_busy", busy, 0);
    check("sa_sda_t_after", sda_t, 1);
    ignore_target = 1'b0;
    tick(T);
    check("sa_rx_cnt", rx_q.size(), 0);

    // ---- reset while driving a 0 read bit
    base = tx_cnt;
    tx_mem[8'(base)] = 8'h3C;
    do_start();
    send_byte(8'h85, ack);
    check("rm_addr_ack", ack, 0);
    ctrl_sda = 1'b1; tick(T);
    scl = 1'b1;      tick(T);
    check("rm_bit7_low", sda_t, 0);
    nreset = 1'b0;
    #1;
    check("rm_sda_t", sda_t, 1);
    check("rm_tx_req", tx_req, 0);
    check("rm_rx_valid", rx_valid, 0);
    check("rm_busy", busy, 0);
    check("rm_rx_data", rx_data, 8'h00);
    tick(2);
    nreset = 1'b1;
    tick(5);
    do_start();
    send_byte(8'h84, ack);
    check("rm_post_ack", ack, 0);
    do_stop();
    tick(T);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- Synthesizable I2C target (responder) for one 7-bit address; the counterpart of the controller side of our open-drain I2C bus.
- Sits behind the SCL/SDA open-drain bus wrapper:
  - samples SCL and SDA as inputs;
  - drives SDA only through a tri-state control (1 = release, 0 = pull low).
- Presents received write bytes and requests transmit bytes through a simple byte interface to the host logic.
- No clock stretching; standard/fast-mode only.

Parameters:
- P_ADDRESS, 7'h42, 7-bit target address matched against the address byte.
- P_SYNC_STAGES, 2, number of flip-flop stages synchronizing I_SCL and I_SDA (minimum 2).

Ports:
- I_CLK  input  1  system clock; all logic is on the rising edge.
- I_NRESET  input  1  asynchronous, active-low reset.
- I_SCL  input  1  SCL line as read back from the bus.
- I_SDA  input  1  SDA line as read back from the bus.
- O_SDA_T  output  1  SDA tri-state control; 1 = high impedance, 0 = pull low.
- I_TX_DATA  input  8  next byte to return on a read; sampled when a read byte is loaded.
- O_TX_REQ  output  1  one-cycle pulse after I_TX_DATA was loaded; host presents the following byte before the next load.
- O_RX_DATA  output  8  last byte written by the controller; holds its value until the next write byte.
- O_RX_VALID  output  1  one-cycle pulse when O_RX_DATA updates.
- O_BUSY  output  1  high from the address ACK until STOP, repeated START, or NACK-terminated read.

Behaviour:
- Reset values:
  - Asserting I_NRESET low immediately forces O_SDA_T=1, O_TX_REQ=0, O_RX_VALID=0, O_BUSY=0, O_RX_DATA=8'h00, state IDLE.
  - This holds mid-transfer too, including while SDA is being pulled low.
  - Synchronizer flops reset to 1 (idle bus).
- Input conditioning:
  - I_SCL and I_SDA pass through P_SYNC_STAGES flops, then one history flop.
  - SCL rise/fall and SDA rise/fall are single-cycle events from comparing the last two stages.
  - Requirement: SCL high and low phases each ≥ P_SYNC_STAGES+3 I_CLK cycles.
- Bus conditions:
  - START: SDA fall while synchronized SCL high.
  - STOP: SDA rise while SCL high.
  - Both are recognized in any state, and win over any data event in the same cycle.
- Bit transfer:
  - Bits are MSB first.
  - Received bits are sampled on the SCL-rise event.
  - O_SDA_T changes only on the cycle after an SCL-fall event, never while SCL is high.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - Bits [7:1] == P_ADDRESS: go to ADDR_ACK.
    - Otherwise: go to IGNORE, with O_SDA_T held at 1.
  - ADDR_ACK: drive O_SDA_T=0 from the SCL fall after bit 8 through the following SCL fall; O_BUSY=1.
    - Address R/W=0: go to WRITE.
    - R/W=1: load I_TX_DATA into the shift register at that 9th SCL fall, pulse O_TX_REQ, drive bit 7, go to READ.
  - WRITE: shift 8 bits, then go to WRITE_ACK.
    - On the 8th SCL-rise, O_RX_DATA takes the byte and O_RX_VALID pulses the following cycle.
  - WRITE_ACK: pull SDA low for the 9th clock, then return to WRITE.
  - READ: drive bits 7..0 on successive SCL falls (O_SDA_T = bit value), then release SDA after the 8th bit and go to READ_ACK.
  - READ_ACK: sample SDA on the 9th SCL-rise.
    - 0 (ACK): at the next SCL fall, load I_TX_DATA, pulse O_TX_REQ, return to READ.
    - 1 (NACK): keep SDA released, O_BUSY=0, go to IGNORE.
  - IGNORE: SDA released; wait for STOP or START.
- Boundary conditions:
  - STOP in any state: go to IDLE, release SDA, O_BUSY=0, discard the partial byte, no O_RX_VALID.
  - Repeated START in any state: go to ADDR and clear the bit counter, with the same discard rules.
  - A START during ADDR_ACK or an ACK cycle releases SDA on the same cycle it is detected.
  - Bit counter is 3 bits, with a 9th-bit flag; no wrap past 9 without an ACK phase.
  - General call (address 0) is not acknowledged unless P_ADDRESS=0.
- Latency:
  - O_SDA_T updates P_SYNC_STAGES+2 I_CLK cycles after the SCL fall at the pin.
  - O_RX_VALID follows P_SYNC_STAGES+3 cycles after the 8th SCL rise at the pin.

Test Plan:
- Write: START, 0x84, 0xA5, STOP → ACK low on both 9th clocks; O_RX_DATA=0xA5; one O_RX_VALID pulse; O_BUSY 1→0 at STOP; O_SDA_T=1 afterwards.
- Read: START, 0x85; I_TX_DATA=0x3C then 0xF0; controller ACKs first byte, NACKs second → SDA bits 0x3C then 0xF0; two O_TX_REQ pulses; SDA released after NACK; O_BUSY=0.
- Wrong address: START, 0x86, 0x11, STOP → O_SDA_T stays 1 throughout; no O_RX_VALID; O_BUSY stays 0.
- Repeated START: START, 0x84, 4 bits of data, START, 0x85 → partial byte dropped with no O_RX_VALID; read ACKed; first read bit driven from I_TX_DATA.
- STOP mid-byte and mid-ACK: STOP during bit 3 of a write; separately, STOP while SDA pulled low → immediate release; state IDLE; no O_RX_VALID.
- Reset mid-transfer: I_NRESET low while O_SDA_T=0 in READ → O_SDA_T=1 in the same cycle; outputs at reset values; next START, 0x84 is ACKed normally.
